// File: rtl/drive_ramp_sequencer.sv
// Ramp sequencer for a two-channel PWM drive: ramps speed codes toward a commanded
// target one code per step, holds for a number of ticks, then decelerates to stop.
module drive_ramp_sequencer #(
  parameter int TICK_DIV   = 128,
  parameter int RAMP_TICKS = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [1:0] CMD_SPEED_A,
  input  logic [1:0] CMD_SPEED_B,
  input  logic [7:0] CMD_TICKS,
  input  logic       ABORT,
  output logic [1:0] DriveA,
  output logic [1:0] DriveB,
  output logic       BUSY,
  output logic       DONE
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] STEP_LAST  = SW'(RAMP_TICKS - 1);

  typedef enum logic [1:0] {IDLE, RAMP, HOLD, DECEL} state_t;

  state_t state, next_state;

  logic [1:0]    tgt_a, tgt_b, pend_a, pend_b;
  logic [7:0]    tgt_ticks, pend_ticks, hold_cnt;
  logic          pend_valid, done_q, ready_en;
  logic [PW-1:0] presc;
  logic [SW-1:0] step_cnt;

  logic [1:0]    a_nxt, b_nxt, tgt_a_nxt, tgt_b_nxt, pend_a_nxt, pend_b_nxt;
  logic [7:0]    tgt_ticks_nxt, pend_ticks_nxt, hold_nxt;
  logic          pend_valid_nxt, done_set;
  logic          tick, step, fire, clear_cnt, hold_expired;

  // Code 3 is not a legal speed; it is folded onto half speed at capture.
  function automatic logic [1:0] fix_code(input logic [1:0] c);
    return (c == 2'd3) ? 2'd1 : c;
  endfunction

  function automatic logic [1:0] step_toward(input logic [1:0] cur, input logic [1:0] tgt);
    if (cur < tgt)      return cur + 2'd1;
    else if (cur > tgt) return cur - 2'd1;
    else                return cur;
  endfunction

  // ready_en keeps CMD_READY low until the first edge after reset is released.
  assign CMD_READY    = ready_en & ~pend_valid & ~ABORT;
  assign fire         = CMD_VALID & CMD_READY;
  assign BUSY         = (state != IDLE);
  assign DONE         = done_q;
  assign tick         = (presc == PRESC_LAST);
  assign step         = tick && (step_cnt == STEP_LAST);
  assign clear_cnt    = (next_state != state) || (state == IDLE);
  assign hold_expired = (hold_cnt == 8'd0) || (tick && (hold_cnt == 8'd1));

  always_comb begin
    next_state     = state;
    a_nxt          = DriveA;
    b_nxt          = DriveB;
    tgt_a_nxt      = tgt_a;
    tgt_b_nxt      = tgt_b;
    tgt_ticks_nxt  = tgt_ticks;
    pend_valid_nxt = pend_valid;
    pend_a_nxt     = pend_a;
    pend_b_nxt     = pend_b;
    pend_ticks_nxt = pend_ticks;
    hold_nxt       = hold_cnt;
    done_set       = 1'b0;

    if (fire && (state != IDLE)) begin
      pend_valid_nxt = 1'b1;
      pend_a_nxt     = fix_code(CMD_SPEED_A);
      pend_b_nxt     = fix_code(CMD_SPEED_B);
      pend_ticks_nxt = CMD_TICKS;
    end

    case (state)
      IDLE: begin
        // A command left pending at the end of a decel is launched from here.
        if (ABORT) begin
          pend_valid_nxt = 1'b0;
        end else if (fire) begin
          tgt_a_nxt     = fix_code(CMD_SPEED_A);
          tgt_b_nxt     = fix_code(CMD_SPEED_B);
          tgt_ticks_nxt = CMD_TICKS;
          next_state    = RAMP;
        end else if (pend_valid) begin
          tgt_a_nxt      = pend_a;
          tgt_b_nxt      = pend_b;
          tgt_ticks_nxt  = pend_ticks;
          pend_valid_nxt = 1'b0;
          next_state     = RAMP;
        end
      end
      RAMP: begin
        if (ABORT) begin
          pend_valid_nxt = 1'b0;
          tgt_a_nxt      = 2'd0;
          tgt_b_nxt      = 2'd0;
          next_state     = DECEL;
        end else begin
          if (step) begin
            a_nxt = step_toward(DriveA, tgt_a);
            b_nxt = step_toward(DriveB, tgt_b);
          end
          if ((a_nxt == tgt_a) && (b_nxt == tgt_b)) begin
            hold_nxt   = tgt_ticks;
            next_state = HOLD;
          end
        end
      end
      HOLD: begin
        if (ABORT) begin
          pend_valid_nxt = 1'b0;
          tgt_a_nxt      = 2'd0;
          tgt_b_nxt      = 2'd0;
          next_state     = DECEL;
        end else if (hold_expired) begin
          // A command arriving on the expiry edge chains directly instead of parking.
          if (pend_valid) begin
            tgt_a_nxt      = pend_a;
            tgt_b_nxt      = pend_b;
            tgt_ticks_nxt  = pend_ticks;
            pend_valid_nxt = 1'b0;
            next_state     = RAMP;
          end else if (fire) begin
            tgt_a_nxt      = fix_code(CMD_SPEED_A);
            tgt_b_nxt      = fix_code(CMD_SPEED_B);
            tgt_ticks_nxt  = CMD_TICKS;
            pend_valid_nxt = 1'b0;
            next_state     = RAMP;
          end else begin
            tgt_a_nxt  = 2'd0;
            tgt_b_nxt  = 2'd0;
            next_state = DECEL;
          end
        end else if (tick) begin
          hold_nxt = hold_cnt - 8'd1;
        end
      end
      DECEL: begin
        if (ABORT) pend_valid_nxt = 1'b0;
        if (step) begin
          a_nxt = step_toward(DriveA, 2'd0);
          b_nxt = step_toward(DriveB, 2'd0);
        end
        if ((a_nxt == 2'd0) && (b_nxt == 2'd0)) begin
          done_set   = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Prescaler and step counter restart on every state entry.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      DriveA     <= 2'd0;
      DriveB     <= 2'd0;
      tgt_a      <= 2'd0;
      tgt_b      <= 2'd0;
      tgt_ticks  <= 8'd0;
      pend_valid <= 1'b0;
      pend_a     <= 2'd0;
      pend_b     <= 2'd0;
      pend_ticks <= 8'd0;
      hold_cnt   <= 8'd0;
      presc      <= '0;
      step_cnt   <= '0;
      done_q     <= 1'b0;
      ready_en   <= 1'b0;
    end else begin
      state      <= next_state;
      DriveA     <= a_nxt;
      DriveB     <= b_nxt;
      tgt_a      <= tgt_a_nxt;
      tgt_b      <= tgt_b_nxt;
      tgt_ticks  <= tgt_ticks_nxt;
      pend_valid <= pend_valid_nxt;
      pend_a     <= pend_a_nxt;
      pend_b     <= pend_b_nxt;
      pend_ticks <= pend_ticks_nxt;
      hold_cnt   <= hold_nxt;
      done_q     <= done_set;
      ready_en   <= 1'b1;
      if (clear_cnt || tick) presc <= '0;
      else                   presc <= presc + 1'b1;
      if (clear_cnt)         step_cnt <= '0;
      else if (tick)         step_cnt <= (step_cnt == STEP_LAST) ? '0 : step_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_drive_ramp_sequencer.sv
// Bench for drive_ramp_sequencer with TICK_DIV=4, RAMP_TICKS=2 (one step = 8 cycles).
// Single-command sequences come from a vector table; chaining, abort and reset are hand sequences.
module tb_drive_ramp_sequencer;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       CMD_VALID = 1'b0;
  logic       ABORT = 1'b0;
  logic [1:0] CMD_SPEED_A = 2'd0;
  logic [1:0] CMD_SPEED_B = 2'd0;
  logic [7:0] CMD_TICKS = 8'd0;
  logic       CMD_READY, BUSY, DONE;
  logic [1:0] DriveA, DriveB;

  int testsRun = 0;
  int testsFailed = 0;

  drive_ramp_sequencer #(.TICK_DIV(4), .RAMP_TICKS(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_SPEED_A(CMD_SPEED_A), .CMD_SPEED_B(CMD_SPEED_B), .CMD_TICKS(CMD_TICKS),
    .ABORT(ABORT), .DriveA(DriveA), .DriveB(DriveB), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // holdAt/doneAt are cycles after the transfer edge; expA/expB are the clamped targets.
  typedef struct {
    int a; int b; int t;
    int expA; int expB; int holdAt; int doneAt;
  } vec_t;
  vec_t vecs[6];

  int histA[0:127], histB[0:127], histBusy[0:127], histReady[0:127];
  int doneAt, doneCnt, jumps, lastK;

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int a, input int b, input int t);
    int waited = 0;
    @(negedge CLK);
    while (!CMD_READY && waited < 200) begin
      @(negedge CLK);
      waited++;
    end
    checkOutput("ready_before_cmd", int'(CMD_READY), 1);
    CMD_VALID   = 1'b1;
    CMD_SPEED_A = 2'(a);
    CMD_SPEED_B = 2'(b);
    CMD_TICKS   = 8'(t);
    @(posedge CLK);
    #1;
    CMD_VALID = 1'b0;
  endtask

  task automatic runWatch(input int budget, input int cmdK, input int ca, input int cb,
                          input int ct, input int abortK);
    for (int i = 0; i < 128; i++) begin
      histA[i] = -1; histB[i] = -1; histBusy[i] = -1; histReady[i] = -1;
    end
    histA[0] = int'(DriveA); histB[0] = int'(DriveB);
    histBusy[0] = int'(BUSY); histReady[0] = int'(CMD_READY);
    doneAt = -1; doneCnt = 0; jumps = 0; lastK = 0;
    for (int k = 1; k <= budget && k < 128; k++) begin
      @(posedge CLK);
      #1;
      histA[k] = int'(DriveA); histB[k] = int'(DriveB);
      histBusy[k] = int'(BUSY); histReady[k] = int'(CMD_READY);
      if (DONE) begin
        doneCnt++;
        if (doneAt < 0) doneAt = k;
      end
      if (histA[k] - histA[k-1] > 1 || histA[k-1] - histA[k] > 1) jumps++;
      if (histB[k] - histB[k-1] > 1 || histB[k-1] - histB[k] > 1) jumps++;
      lastK = k;
      if (k == cmdK) begin
        CMD_VALID = 1'b1; CMD_SPEED_A = 2'(ca); CMD_SPEED_B = 2'(cb); CMD_TICKS = 8'(ct);
      end
      if (k == cmdK + 1) CMD_VALID = 1'b0;
      if (k == abortK) ABORT = 1'b1;
      if (k == abortK + 1) ABORT = 1'b0;
      if (doneAt >= 0 && k >= doneAt + 2) break;
    end
  endtask

  function automatic int peakA();
    int m = 0;
    for (int k = 0; k <= lastK; k++) if (histA[k] > m) m = histA[k];
    return m;
  endfunction

  function automatic int peakB();
    int m = 0;
    for (int k = 0; k <= lastK; k++) if (histB[k] > m) m = histB[k];
    return m;
  endfunction

  function automatic int zerosBeforeDone();
    int n = 0;
    int lim = (doneAt < 0) ? lastK + 1 : doneAt;
    for (int k = 8; k < lim; k++) if (histA[k] == 0 && histB[k] == 0) n++;
    return n;
  endfunction

  initial begin
    int cnt;
    vecs[0] = '{a:2, b:1, t:3, expA:2, expB:1, holdAt:16, doneAt:44};
    vecs[1] = '{a:3, b:0, t:0, expA:1, expB:0, holdAt:8,  doneAt:17};
    vecs[2] = '{a:0, b:0, t:1, expA:0, expB:0, holdAt:1,  doneAt:6};
    vecs[3] = '{a:2, b:2, t:2, expA:2, expB:2, holdAt:16, doneAt:40};
    vecs[4] = '{a:1, b:2, t:0, expA:1, expB:2, holdAt:16, doneAt:33};
    vecs[5] = '{a:0, b:3, t:1, expA:0, expB:1, holdAt:8,  doneAt:20};

    // Reset values while RST_N is low
    #3;
    checkOutput("rst_driveA", int'(DriveA), 0);
    checkOutput("rst_driveB", int'(DriveB), 0);
    checkOutput("rst_busy", int'(BUSY), 0);
    checkOutput("rst_done", int'(DONE), 0);
    checkOutput("rst_ready", int'(CMD_READY), 0);
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("rst_ready_clocked", int'(CMD_READY), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    checkOutput("ready_after_reset", int'(CMD_READY), 1);

    // Abort and valid together in IDLE: no transfer
    @(negedge CLK);
    ABORT = 1'b1; CMD_VALID = 1'b1; CMD_SPEED_A = 2'd2; CMD_SPEED_B = 2'd2; CMD_TICKS = 8'd1;
    #1;
    checkOutput("abort_idle_ready", int'(CMD_READY), 0);
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("abort_idle_busy", int'(BUSY), 0);
    checkOutput("abort_idle_driveA", int'(DriveA), 0);
    ABORT = 1'b0; CMD_VALID = 1'b0;
    @(posedge CLK);
    #1;
    checkOutput("abort_idle_busy_after", int'(BUSY), 0);

    // Table of single-command sequences from IDLE
    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].a, vecs[v].b, vecs[v].t);
      runWatch(100, -1, 0, 0, 0, -1);
      checkOutput($sformatf("v%0d_holdA", v), histA[vecs[v].holdAt], vecs[v].expA);
      checkOutput($sformatf("v%0d_holdB", v), histB[vecs[v].holdAt], vecs[v].expB);
      checkOutput($sformatf("v%0d_holdA_next", v), histA[vecs[v].holdAt + 1], vecs[v].expA);
      checkOutput($sformatf("v%0d_busy_hold", v), histBusy[vecs[v].holdAt], 1);
      checkOutput($sformatf("v%0d_peakA", v), peakA(), vecs[v].expA);
      checkOutput($sformatf("v%0d_peakB", v), peakB(), vecs[v].expB);
      checkOutput($sformatf("v%0d_done_cycle", v), doneAt, vecs[v].doneAt);
      checkOutput($sformatf("v%0d_done_pulses", v), doneCnt, 1);
      checkOutput($sformatf("v%0d_idle_at_done", v), (doneAt < 0) ? -1 : histBusy[doneAt], 0);
      checkOutput($sformatf("v%0d_jumps", v), jumps, 0);
    end

    // Chained command parked during HOLD, launched at expiry without stopping
    applyStimulus(2, 2, 4);
    runWatch(120, 18, 1, 0, 0, -1);
    checkOutput("chain_ready_free", histReady[18], 1);
    checkOutput("chain_ready_full", histReady[20], 0);
    checkOutput("chain_hold_A", histA[16], 2);
    checkOutput("chain_hold_B", histB[16], 2);
    checkOutput("chain_prestep_A", histA[39], 2);
    checkOutput("chain_step1_A", histA[40], 1);
    checkOutput("chain_step1_B", histB[40], 1);
    checkOutput("chain_step2_A", histA[48], 1);
    checkOutput("chain_step2_B", histB[48], 0);
    checkOutput("chain_no_stop", zerosBeforeDone(), 0);
    checkOutput("chain_done_cycle", doneAt, 57);
    checkOutput("chain_done_pulses", doneCnt, 1);
    checkOutput("chain_jumps", jumps, 0);

    // Abort pulse in HOLD with a pending command
    applyStimulus(2, 2, 6);
    runWatch(120, 18, 1, 1, 0, 22);
    checkOutput("abort_pending_full", histReady[21], 0);
    checkOutput("abort_busy_decel", histBusy[23], 1);
    checkOutput("abort_pending_cleared", histReady[24], 1);
    checkOutput("abort_hold_A", histA[30], 2);
    checkOutput("abort_step1_A", histA[31], 1);
    checkOutput("abort_step1_B", histB[31], 1);
    checkOutput("abort_done_cycle", doneAt, 39);
    checkOutput("abort_done_pulses", doneCnt, 1);
    checkOutput("abort_jumps", jumps, 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK);
      #1;
      if (BUSY) cnt++;
    end
    checkOutput("abort_no_relaunch", cnt, 0);

    // Asynchronous reset in the middle of a ramp
    applyStimulus(2, 2, 1);
    repeat (9) @(posedge CLK);
    #1;
    checkOutput("midramp_busy", int'(BUSY), 1);
    checkOutput("midramp_driveA", int'(DriveA), 1);
    #2;
    RST_N = 1'b0;
    #1;
    checkOutput("async_rst_driveA", int'(DriveA), 0);
    checkOutput("async_rst_driveB", int'(DriveB), 0);
    checkOutput("async_rst_busy", int'(BUSY), 0);
    checkOutput("async_rst_ready", int'(CMD_READY), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge CLK);
      #1;
      if (DONE || BUSY) cnt++;
    end
    checkOutput("post_rst_quiet", cnt, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/drive_ramp_sequencer.md
DRIVE_RAMP_SEQUENCER -- requirements
Module: drive_ramp_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: CLK (all state changes on posedge) and RST_N.
REQ-002 Parameter TICK_DIV SHALL default to 128 and set the number of CLK cycles per tick, matching one PWM period.
REQ-003 Parameter RAMP_TICKS SHALL default to 4 and set the number of ticks between ramp steps.
REQ-004 Port CLK SHALL be input, 1 bit: system clock.
REQ-005 Port RST_N SHALL be input, 1 bit: asynchronous active-low reset.
REQ-006 Port CMD_VALID SHALL be input, 1 bit: command offered.
REQ-007 Port CMD_READY SHALL be output, 1 bit: command can be accepted.
REQ-008 Ports CMD_SPEED_A and CMD_SPEED_B SHALL be inputs, 2 bits each: target speed code, where 0 = stop, 1 = half, 2 = three-quarter.
REQ-009 Port CMD_TICKS SHALL be input, 8 bits: hold duration in ticks.
REQ-010 Port ABORT SHALL be input, 1 bit, level-sensitive: forced ramp-down.
REQ-011 Ports DriveA and DriveB SHALL be outputs, 2 bits each, registered: speed codes fed to the PWM generator.
REQ-012 Port BUSY SHALL be output, 1 bit: high whenever the state is not IDLE.
REQ-013 Port DONE SHALL be output, 1 bit: single-cycle pulse when a sequence returns to stop.

Function
REQ-014 A command SHALL transfer on a posedge where CMD_VALID and CMD_READY are both 1.
REQ-015 CMD_READY SHALL equal ~PENDING & ~ABORT, where PENDING is a one-entry command register.
REQ-016 A speed code of 3 SHALL be treated as 1 on capture, so DriveA and DriveB never output 3.
REQ-017 The FSM SHALL have exactly four states: IDLE, RAMP, HOLD, DECEL.
REQ-018 On a transfer in IDLE, the block SHALL load the targets directly (PENDING unused) and enter RAMP on that same edge.
REQ-019 On a transfer in any other state, the command SHALL be stored in PENDING.
REQ-020 A prescaler and a step counter SHALL both clear on every state entry.
REQ-021 A tick SHALL occur every TICK_DIV cycles after state entry.
REQ-022 A step SHALL occur every RAMP_TICKS ticks, so steps fall at TICK_DIV*RAMP_TICKS, 2x, 3x, ... cycles after entry.
REQ-023 RAMP: at each step, DriveA and DriveB SHALL each move one code toward their own target, independently.
REQ-024 RAMP SHALL go to HOLD on the edge where both outputs equal their targets, loading the hold counter from the captured CMD_TICKS.
REQ-025 If the targets equal the current outputs on entry, RAMP SHALL exit to HOLD on its first cycle.
REQ-026 HOLD: the hold counter SHALL decrement once per tick, and the hold SHALL expire when the counter reaches 0.
REQ-027 A CMD_TICKS value of 0 SHALL make HOLD expire on its first cycle.
REQ-028 On hold expiry with PENDING set, the block SHALL load PENDING into the targets, clear PENDING, and enter RAMP without passing through stop.
REQ-029 On hold expiry without PENDING, both targets SHALL be set to 0 and the block SHALL enter DECEL.
REQ-030 DECEL SHALL step both outputs toward 0 using the step timing above.
REQ-031 When both outputs are 0, DECEL SHALL go to IDLE and pulse DONE for 1 cycle.
REQ-032 DECEL entered with both outputs already 0 SHALL exit to IDLE on its first cycle.
REQ-033 ABORT=1 in RAMP or HOLD SHALL clear PENDING, set both targets to 0, and enter DECEL on the next edge.
REQ-034 ABORT=1 in DECEL SHALL clear PENDING only; DECEL continues.
REQ-035 ABORT=1 in IDLE SHALL clear PENDING and hold the block in IDLE.
REQ-036 When ABORT and CMD_VALID are both 1, abort SHALL win and no transfer SHALL occur.
REQ-037 Outputs SHALL never jump more than one code per step, in either direction.

Reset
REQ-038 While RST_N=0, all outputs SHALL take their reset values immediately, independent of CLK: DriveA=0, DriveB=0, BUSY=0, DONE=0, CMD_READY=0.
REQ-039 While RST_N=0, internal state SHALL be forced to: state=IDLE, PENDING cleared, all counters 0.
REQ-040 On the first posedge after RST_N rises, CMD_READY SHALL be 1 (subject to REQ-015).
REQ-041 A reset asserted mid-ramp or mid-hold SHALL discard all commands with no DONE pulse.

Verification (TICK_DIV=4, RAMP_TICKS=2, so one step = 8 cycles)
REQ-042 Scenario A: transfer A=2, B=1, TICKS=3 in IDLE at edge N -> DriveA/DriveB = 1/1 at N+8; 2/1 at N+16 with HOLD entered; DECEL entered at N+28; 1/0 at N+36; 0/0 at N+44 with DONE=1 for exactly 1 cycle.
REQ-043 Scenario B: during HOLD of A=2/B=2, transfer A=1/B=0 (CMD_READY then drops to 0) -> after expiry, outputs step 2/2 -> 1/1 -> 1/0 with no 0/0 between, and no DONE until the final decel.
REQ-044 Scenario C: ABORT pulse during HOLD with PENDING full -> DECEL next edge, PENDING cleared, outputs reach 0 one code per step, 1 DONE pulse.
REQ-045 Scenario D: CMD_SPEED_A=3, CMD_TICKS=0 -> DriveA never exceeds 1; HOLD lasts 1 cycle.
REQ-046 Scenario E: RST_N low mid-RAMP, asynchronously to CLK -> outputs 0 and BUSY=0 before the next edge.
REQ-047 Scenario F: ABORT=1 with CMD_VALID=1 in IDLE -> CMD_READY=0, no transfer, BUSY stays 0.
